// File: rtl/pattern_pkg.sv
// pattern_pkg: shared FSM state encoding and width helper for the serial pattern transmitter.
//  state_t : IDLE=00, SHIFT=01, GAP=11, DONE=10 (visible on the debug state port)
//  len_w() : width of a length/bit-count field able to hold 0..width
package pattern_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b11,
    S_DONE  = 2'b10
  } state_t;
  function automatic int len_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-load shift register with a registered MSB-first serial output.
//  clk, reset_n : clock, asynchronous active-low reset
//  load         : capture data and emit its bit [len-1] on the same edge
//  shift        : emit the next bit and advance the register
//  data, len    : parallel word and active length (len-1 is the first bit sent)
//  ser          : registered serial bit; IDLE_LVL whenever neither load nor shift
module piso_shift
  import pattern_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LEN_W    = len_w(WIDTH),
  parameter bit IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             ser
);
  logic [WIDTH-1:0] shreg, src, aligned;
  // the emitted bit and the post-shift contents come from the same source word,
  // so a load both sends the first bit and leaves the second one at position len-1
  assign src     = load ? data : shreg;
  assign aligned = src >> (len - 1'b1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shreg <= '0;
      ser   <= IDLE_LVL;
    end else begin
      ser <= (load | shift) ? aligned[0] : IDLE_LVL;
      if (load | shift) shreg <= src << 1;
    end
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends a latched pattern MSB-first, optionally repeated with idle gaps.
//  clk, reset_n       : clock, asynchronous active-low reset
//  start              : transmission request, honoured only in IDLE with 1<=len<=WIDTH
//  pattern, len, reps : bits to send, bits per repetition, extra repetitions
//  out, out_valid     : registered serial data and its qualifier
//  busy, done         : high through SHIFT/GAP; one-cycle pulse in DONE
//  state              : current FSM state
// The first bit is registered on the accepting edge, so state, out_valid and
// done always describe the same cycle.
module serial_pattern_tx
  import pattern_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int REP_W    = 4,
  parameter int GAP      = 2,
  parameter bit IDLE_LVL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         pattern,
  input  logic [len_w(WIDTH)-1:0]  len,
  input  logic [REP_W-1:0]         reps,
  output logic                     out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state
);
  localparam int LW    = len_w(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  state_t           cur, nxt;
  logic [WIDTH-1:0] pat_q;
  logic [LW-1:0]    len_q, cnt;
  logic [REP_W-1:0] reps_left;
  logic [GAP_W-1:0] gcnt;
  logic             load, shift, len_ok, rep_end;
  assign len_ok  = (len != '0) && (len <= LW'(WIDTH));
  // cnt counts bits already emitted in this repetition
  assign rep_end = (cur == S_SHIFT) && (cnt == len_q);
  always_comb begin
    nxt   = cur;
    load  = 1'b0;
    shift = 1'b0;
    case (cur)
      S_IDLE: if (start && len_ok) begin
        nxt  = S_SHIFT;
        load = 1'b1;
      end
      S_SHIFT: if (!rep_end) shift = 1'b1;
        else if (reps_left == '0) nxt = S_DONE;
        else if (GAP == 0) load = 1'b1;
        else nxt = S_GAP;
      S_GAP: if (gcnt == '0) begin
        nxt  = S_SHIFT;
        load = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur       <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      reps_left <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      out_valid <= 1'b0;
    end else begin
      cur       <= nxt;
      out_valid <= load | shift;
      if (cur == S_IDLE && load) begin
        pat_q     <= pattern;
        len_q     <= len;
        reps_left <= reps;
      end else if (rep_end && reps_left != '0) reps_left <= reps_left - 1'b1;
      cnt  <= load ? LW'(1) : shift ? cnt + 1'b1 : cnt;
      gcnt <= (cur == S_SHIFT && nxt == S_GAP) ? GAP_W'(GAP - 1) :
              (cur == S_GAP && gcnt != '0) ? gcnt - 1'b1 : gcnt;
    end
  // repetitions reload from the latched copy so inputs may change freely mid-run
  piso_shift #(.WIDTH(WIDTH), .LEN_W(LW), .IDLE_LVL(IDLE_LVL)) u_piso (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .data    (cur == S_IDLE ? pattern : pat_q),
    .len     (cur == S_IDLE ? len : len_q),
    .ser     (out)
  );
  assign busy  = (cur == S_SHIFT) || (cur == S_GAP);
  assign done  = (cur == S_DONE);
  assign state = cur;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: randomized bench for serial_pattern_tx against a per-cycle expectation queue.
module tb_serial_pattern_tx;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start8 = 1'b0, start9 = 1'b0;
  logic [8:0] pat = '0;
  logic [3:0] len = '0, reps = '0;
  logic       out8, valid8, busy8, done8, out9, valid9, busy9, done9;
  logic [1:0] st8, st9;
  logic [5:0] obs8, obs9;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP(2), .IDLE_LVL(1'b0)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .pattern(pat[7:0]), .len(len), .reps(reps),
    .out(out8), .out_valid(valid8), .busy(busy8), .done(done8), .state(st8)
  );
  serial_pattern_tx #(.WIDTH(9), .REP_W(4), .GAP(0), .IDLE_LVL(1'b0)) dut9 (
    .clk(clk), .reset_n(reset_n), .start(start9), .pattern(pat), .len(len), .reps(reps),
    .out(out9), .out_valid(valid9), .busy(busy9), .done(done9), .state(st9)
  );

  assign obs8 = {st8, busy8, done8, valid8, out8};
  assign obs9 = {st9, busy9, done9, valid9, out9};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected {state,busy,done,out_valid,out} for every cycle after the accepting edge
  task automatic run_tx(input bit sel, input logic [8:0] p, input logic [3:0] l, input logic [3:0] r);
    logic [5:0] q[$];
    int g;
    g = sel ? 0 : 2;
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = int'(l) - 1; i >= 0; i--) q.push_back({5'b01101, p[i]});
      if (k < int'(r)) repeat (g) q.push_back(6'b111000);
    end
    q.push_back(6'b100100);
    q.push_back(6'b000000);
    @(negedge clk);
    pat = p; len = l; reps = r;
    if (sel) start9 = 1'b1; else start8 = 1'b1;
    foreach (q[j]) begin
      @(negedge clk);
      check($sformatf("tx%0d_w%0d_l%0d_r%0d_c%0d", j, sel ? 9 : 8, l, r, j), sel ? obs9 : obs8, q[j]);
      if (j == q.size() - 1) begin
        start8 = 1'b0; start9 = 1'b0;
      end else begin
        pat = 9'($urandom); len = 4'($urandom); reps = 4'($urandom);
        if (sel) start9 = 1'($urandom); else start8 = 1'($urandom);
      end
    end
  endtask

  task automatic bad_len(input logic [3:0] l);
    @(negedge clk);
    pat = 9'($urandom); len = l; start8 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check($sformatf("badlen%0d", l), obs8, 6'b0);
    end
    start8 = 1'b0;
  endtask

  task automatic reset_mid;
    logic [7:0] p;
    p = 8'hA5;
    @(negedge clk);
    pat = {1'b0, p}; len = 4'd8; reps = 4'd0; start8 = 1'b1;
    for (int i = 7; i >= 4; i--) begin
      @(negedge clk);
      start8 = 1'b0;
      check($sformatf("rstmid_bit%0d", 7 - i), obs8, {5'b01101, p[i]});
    end
    #1 reset_n = 1'b0;
    #1 check("rst_async", obs8, 6'b0);
    @(negedge clk);
    check("rst_hold", obs8, 6'b0);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_release", obs8, 6'b0);
    end
  endtask

  // feeds a 1->0 transition counter the way a downstream Mealy detector would see the stream
  task automatic loopback;
    bit         seen;
    int         nb, falls;
    logic       prev;
    logic [8:0] s;
    seen = 0; nb = 0; falls = 0; prev = 1'b0; s = '0;
    @(negedge clk);
    pat = 9'b010111100; len = 4'd9; reps = 4'd0; start9 = 1'b1;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      start9 = 1'b0;
      if (valid9) begin
        if (nb > 0 && prev && !out9) falls++;
        prev = out9;
        s = {s[7:0], out9};
        nb++;
      end
      if (done9) seen = 1;
    end
    check("loop_done_seen", 32'(seen), 32'd1);
    check("loop_nbits", nb, 9);
    check("loop_stream", s, 9'b010111100);
    check("loop_falls", falls, 2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset8", obs8, 6'b0);
    check("reset9", obs9, 6'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset8_after", obs8, 6'b0);
    run_tx(1'b0, 9'b0_0000_0101, 4'd3, 4'd0);
    run_tx(1'b0, 9'b0_1011_0110, 4'd8, 4'd1);
    bad_len(4'd0);
    bad_len(4'd9);
    bad_len(4'd15);
    run_tx(1'b0, 9'($urandom), 4'd1, 4'd2);
    reset_mid();
    for (int t = 0; t < 15; t++)
      run_tx(1'b0, 9'($urandom), 4'($urandom_range(1, 8)), 4'($urandom_range(0, 3)));
    loopback();
    for (int t = 0; t < 6; t++)
      run_tx(1'b1, 9'($urandom), 4'($urandom_range(1, 9)), 4'($urandom_range(0, 3)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
